// File: rtl/trace_fetch.sv
// Read-side sequencer for trace_buffer: sweeps every column on line_start and
// streams {column, height, side} through a small FWFT FIFO to the renderer.
module trace_fetch #(
    parameter int NUM_COLS = 640,
    parameter int DEPTH    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start,
    output logic       tb_cs,
    output logic       tb_oe,
    output logic       tb_we,
    output logic [9:0] tb_column,
    input  logic [7:0] tb_height,
    input  logic       tb_side,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_column,
    output logic [7:0] out_height,
    output logic       out_side,
    output logic       busy,
    output logic       line_done,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    // Output handshake: an entry transfers on every cycle where out_valid && out_ready.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [9:0]    LAST_COL = 10'(NUM_COLS - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [9:0]     col, col_prev;
    logic           inflight;
    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [18:0]    mem [DEPTH];
    logic [18:0]    head;
    logic           issue, push, pop, done_nxt, line_done_q;

    // A read may only be issued if its result is guaranteed a FIFO slot.
    assign issue = (state == FETCH) && ((int'(count) + int'(inflight)) < DEPTH);
    assign push  = inflight;
    assign pop   = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (line_start) state_nxt = FETCH;
            FETCH: if (issue && col == LAST_COL) state_nxt = DRAIN;
            DRAIN: begin
                if (!inflight && count == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            col         <= '0;
            col_prev    <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            line_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            line_done_q <= done_nxt;
            inflight    <= issue;
            if (state == IDLE && line_start) begin
                col <= '0;
            end else if (issue) begin
                col      <= col + 10'd1;
                col_prev <= col;
            end
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Data is captured the cycle after issue, while the buffer still drives it.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= {col_prev, tb_height, tb_side};
    end

    assign head       = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign out_column = out_valid ? head[18:9] : '0;
    assign out_height = out_valid ? head[8:1]  : '0;
    assign out_side   = out_valid ? head[0]    : 1'b0;

    assign tb_cs     = (state == FETCH) || (state == DRAIN && inflight);
    assign tb_oe     = tb_cs;
    assign tb_we     = 1'b0;
    assign tb_column = (state == FETCH) ? col : '0;
    assign busy      = (state != IDLE);
    assign line_done = line_done_q;
    assign overrun   = line_start && busy;
    assign dbg_state = state;

endmodule

// File: tb/tb_trace_fetch.sv
// Bench for trace_fetch: behavioural trace_buffer, randomized contents and
// backpressure, expected column stream built from the buffer contents.
module tb_trace_fetch;

    localparam int NUM_COLS = 640;
    localparam int DEPTH    = 2;
    localparam int BUDGET   = 6000;

    logic       clk = 1'b0;
    logic       reset, line_start, out_ready;
    logic       tb_cs, tb_oe, tb_we, tb_side;
    logic [9:0] tb_column, out_column;
    logic [7:0] tb_height, out_height;
    logic       out_valid, out_side, busy, line_done, overrun;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [18:0] exp_q[$];

    // Clock / reset
    always #5 clk = ~clk;

    trace_fetch #(.NUM_COLS(NUM_COLS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .line_start(line_start),
        .tb_cs(tb_cs), .tb_oe(tb_oe), .tb_we(tb_we), .tb_column(tb_column),
        .tb_height(tb_height), .tb_side(tb_side),
        .out_valid(out_valid), .out_ready(out_ready), .out_column(out_column),
        .out_height(out_height), .out_side(out_side),
        .busy(busy), .line_done(line_done), .overrun(overrun), .dbg_state(dbg_state)
    );

    // Behavioural trace_buffer: registers on cs&oe, drives only while cs&oe holds.
    logic [7:0] mem_h [NUM_COLS];
    logic       mem_s [NUM_COLS];
    logic [7:0] rd_h = 8'h00;
    logic       rd_s = 1'b0;
    always @(posedge clk) begin
        if (tb_cs && tb_oe && tb_column < 10'(NUM_COLS)) begin
            rd_h <= mem_h[tb_column];
            rd_s <= mem_s[tb_column];
        end
    end
    assign tb_height = (tb_cs && tb_oe) ? rd_h : 8'h00;
    assign tb_side   = (tb_cs && tb_oe) ? rd_s : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int c = 0; c < NUM_COLS; c++) begin
            mem_h[c] = 8'(c);
            mem_s[c] = 1'(c & 1);
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < NUM_COLS; c++) begin
            mem_h[c] = 8'($urandom_range(0, 255));
            mem_s[c] = 1'($urandom_range(0, 1));
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 held low for 30 cycles then ready.
    task automatic run_sweep(input string name, input int ready_mode, input int ovr_at,
                             input int abort_col, input bit chain, input bit pre_started);
        int  k, last_k, beats, ovr_cnt, we_bad;
        bit  done, aborted;
        logic [18:0] exp;
        exp_q.delete();
        for (int c = 0; c < NUM_COLS; c++) exp_q.push_back({10'(c), mem_h[c], mem_s[c]});
        k = pre_started ? 1 : 0;
        last_k = -10; beats = 0; ovr_cnt = 0; we_bad = 0; done = 0; aborted = 0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (k >= 30);
            endcase
            line_start = (k == 0 && !pre_started) || (k == ovr_at) || (chain && line_done);
            #1;
            if (tb_we) we_bad++;
            if (overrun) ovr_cnt++;
            if (k == 2) check({name, "_valid_c2"}, out_valid, 0);
            if (k == 3) check({name, "_first_beat"}, {out_valid, out_column}, {1'b1, 10'd0});
            if (k == ovr_at) check({name, "_overrun"}, overrun, 1);
            if (ready_mode == 2 && k == 29)
                check({name, "_stall"}, {tb_column, out_valid, out_column}, {10'd2, 1'b1, 10'd0});
            if (k == last_k + 1 && exp_q.size() == 0)
                check({name, "_busy_after_pop"}, busy, 1);
            if (line_done) begin
                check({name, "_done_lat"}, k, last_k + 2);
                check({name, "_busy_done"}, busy, 0);
                if (chain) check({name, "_chain_overrun"}, overrun, 0);
                done = 1;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_beat"}, out_column, 10'h3ff);
                end else begin
                    exp = exp_q.pop_front();
                    check({name, "_beat"}, {out_column, out_height, out_side}, exp);
                end
                beats++;
                last_k = k;
                if (abort_col >= 0 && int'(out_column) == abort_col) begin
                    aborted = 1;
                    done = 1;
                end
            end
            k++;
        end
        if (aborted) begin
            @(negedge clk);
            reset = 1'b1; line_start = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check({name, "_abort_state"}, {tb_cs, out_valid, busy, line_done}, 4'b0000);
            exp_q.delete();
        end else begin
            check({name, "_finished"}, done, 1);
            check({name, "_beats"}, beats, NUM_COLS);
            check({name, "_overrun_count"}, ovr_cnt, (ovr_at > 0) ? 1 : 0);
        end
        check({name, "_we_low"}, we_bad, 0);
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_bus", {tb_cs, tb_oe, tb_we, tb_column}, 13'd0);
        check("reset_out", {out_valid, out_column, out_height, out_side}, 20'd0);
        check("reset_flags", {busy, line_done, overrun}, 3'b000);

        fill_ramp();
        run_sweep("t1_ramp", 0, -1, -1, 0, 0);

        fill_random();
        run_sweep("t2_stall", 2, -1, -1, 0, 0);

        fill_random();
        run_sweep("t3_toggle", 1, -1, -1, 0, 0);

        fill_random();
        run_sweep("t4_overrun", 1, 100, -1, 0, 0);

        fill_random();
        run_sweep("t5_abort", 0, -1, 300, 0, 0);
        run_sweep("t5_restart", 1, -1, -1, 0, 0);

        fill_random();
        run_sweep("t6_first", 0, -1, -1, 1, 0);
        run_sweep("t6_second", 1, -1, -1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
